// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, limits and state encoding for the serial BCD adder
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: one-digit BCD add or nines-complement subtract with decimal correction
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  input  logic               sub,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);
  logic [DIGIT_W-1:0] bx;
  logic [DIGIT_W:0]   d;
  // binary digit sum, then fold 10..19 back into 0..9 with a +6 correction
  always_comb begin
    bx = sub ? BCD_MAX - b : b;
    d  = {1'b0, a} + {1'b0, bx} + {{DIGIT_W{1'b0}}, ci};
    co = d > {1'b0, BCD_MAX};
    s  = co ? d[DIGIT_W-1:0] + 4'd6 : d[DIGIT_W-1:0];
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder/subtractor, LSD first
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic                  Sub,
  input  logic                  Cin,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Sum,
  output logic                  Cout,
  output logic                  Err
);
  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sub_q, sub_d, carry_q, carry_d, bad_q, bad_d;
  logic          cout_q, cout_d, err_q, err_d, done_q, done_d;
  logic          bad_in, dig_co;
  logic [DIGIT_W-1:0] dig_s;
  bcd_digit_add u_dig (
    .a   (a_q[DIGIT_W*idx_q +: DIGIT_W]),
    .b   (b_q[DIGIT_W*idx_q +: DIGIT_W]),
    .ci  (carry_q),
    .sub (sub_q),
    .s   (dig_s),
    .co  (dig_co)
  );
  // flag any operand digit outside 0..9
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad_in = bad_in | (A[DIGIT_W*i +: DIGIT_W] > BCD_MAX) | (B[DIGIT_W*i +: DIGIT_W] > BCD_MAX);
  end
  // sequencing: capture in IDLE, one digit per RUN cycle, publish results leaving DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (Start) begin
        a_d     = A;
        b_d     = B;
        sub_d   = Sub;
        carry_d = Sub ? ~Cin : Cin;
        idx_d   = '0;
        bad_d   = bad_in;
        work_d  = '0;
        state_d = bad_in ? S_DONE : S_RUN;
      end
      S_RUN: begin
        work_d[DIGIT_W*idx_q +: DIGIT_W] = dig_s;
        carry_d = dig_co;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == IW'(DIGITS - 1) ? S_DONE : S_RUN;
      end
      S_DONE: begin
        sum_d   = bad_q ? '0 : work_q;
        cout_d  = ~bad_q & carry_q;
        err_d   = bad_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state register; reset aborts any operation and clears results
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
  assign Busy = (state_q != S_IDLE) | done_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Err  = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed checks of the serial BCD adder with DIGITS = 4
module tb_bcd_serial_adder;
  logic        clk = 1'b0;
  logic        Resetn, Start, Sub, Cin, Busy, Done, Cout, Err;
  logic [15:0] A, B, Sum;
  int          vectors = 0;
  int          miscompares = 0;
  int          dones;
  logic [15:0] first_sum;
  logic        first_cout;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .Clock(clk), .Resetn(Resetn), .Start(Start), .Sub(Sub), .Cin(Cin),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input logic c, input logic [15:0] es,
                    input logic ec, input logic ee, input int lat);
    int n;
    logic [15:0] prev;
    prev = Sum;
    @(negedge clk);
    A = a; B = b; Sub = s; Cin = c; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1 n++;
      if (n == 1) begin
        chk({tag, " busy"}, {31'd0, Busy}, 32'd1);
        if (Done !== 1'b1) chk({tag, " sum held"}, {16'd0, Sum}, {16'd0, prev});
      end
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " sum"}, {16'd0, Sum}, {16'd0, es});
    chk({tag, " cout/err"}, {30'd0, Cout, Err}, {30'd0, ec, ee});
    @(posedge clk);
    #1 chk({tag, " done/busy drop"}, {30'd0, Done, Busy}, 32'd0);
    chk({tag, " sum hold"}, {16'd0, Sum}, {16'd0, es});
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset outputs", {13'd0, Busy, Done, Sum, Cout, Err}, 32'd0);
    @(negedge clk) Resetn = 1'b1;

    op("add 0999+0001", 16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 5);
    op("add 9999+0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
    op("add 0000+0000+1", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 5);
    op("sub 0500-0123", 16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0, 5);
    op("sub 0123-0500", 16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 5);
    op("sub 0005-0005-1", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 5);
    op("err A=00A1", 16'h00A1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    op("clear err 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 5);

    // Start during RUN with new operands must be ignored
    @(negedge clk);
    A = 16'h0500; B = 16'h0123; Sub = 1'b1; Cin = 1'b0; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    @(negedge clk);
    A = 16'h9999; B = 16'h9999; Sub = 1'b0; Start = 1'b1;
    @(negedge clk) Start = 1'b0;
    dones = 0; first_sum = '0; first_cout = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (Done === 1'b1) begin
        if (dones == 0) begin first_sum = Sum; first_cout = Cout; end
        dones++;
      end
    end
    chk("start in run: done count", dones, 1);
    chk("start in run: sum", {16'd0, first_sum}, 32'h0377);
    chk("start in run: cout", {31'd0, first_cout}, 32'd1);

    // reset during the third RUN cycle aborts with no Done
    @(negedge clk);
    A = 16'h0999; B = 16'h0001; Sub = 1'b0; Cin = 1'b0; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (2) @(posedge clk);
    #2 Resetn = 1'b0;
    #1 chk("reset mid-run outputs", {13'd0, Busy, Done, Sum, Cout, Err}, 32'd0);
    @(negedge clk) Resetn = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (Done === 1'b1) dones++;
    end
    chk("reset mid-run: no done", dones, 0);
    op("after reset 0123-0500", 16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
